// File: rtl/serial_rx_pkg.sv
// Shared types and default constants for the SerialComm character receiver.
package serial_rx_pkg;

    // PARITY is only reachable when SERIAL_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/serial_char_receiver_sync2.sv
// Two-flop synchronizer for one asynchronous input, resetting to a chosen idle level.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_char_receiver.sv
// 8N1 character receiver started by the start-bit detector; mid-bit sampling at OVERSAMPLE clk/bit.
// Optional even-parity bit between data and stop bits when SERIAL_RX_PARITY_EN is defined.
module serial_char_receiver
    import serial_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 data,
    output logic                 char_complete,
    output logic                 char_valid,
    output logic [DATA_BITS-1:0] rx_char,
    output logic                 framing_error,
    output logic                 parity_error
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic en_s;
    logic data_s;

    rx_state_t             state, state_next;
    logic [TICK_W-1:0]     tick_cnt, tick_next;
    logic [BIT_W-1:0]      bit_cnt, bit_next;
    logic [DATA_BITS-1:0]  shreg, shreg_next;
    logic                  abort, abort_next;
    logic                  armed, armed_next;
    logic                  done_enter;

`ifdef SERIAL_RX_PARITY_EN
    logic par_bit, par_next;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    sync2 #(.RESET_VAL(1'b1)) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .d     (data),
        .q     (data_s)
    );

    sync2 #(.RESET_VAL(1'b0)) u_sync_enable (
        .clk   (clk),
        .reset (reset),
        .d     (enable),
        .q     (en_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            abort    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            abort    <= abort_next;
            armed    <= armed_next;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        abort_next = abort;
        // en_s lags the detector's clear, so a new frame needs en_s low once after DONE.
        armed_next = armed | ~en_s;
`ifdef SERIAL_RX_PARITY_EN
        par_next   = par_bit;
`endif

        case (state)
            IDLE: begin
                if (en_s && armed) begin
                    state_next = START;
                    tick_next  = '0;
                    bit_next   = '0;
                    abort_next = 1'b0;
                end
            end

            START: begin
                if (tick_cnt == HALF_LAST) begin
                    tick_next = '0;
                    if (data_s) begin
                        state_next = DONE;
                        abort_next = 1'b1;
                    end else begin
                        state_next = SHIFT;
                    end
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end

            SHIFT: begin
                if (tick_cnt == FULL_LAST) begin
                    tick_next  = '0;
                    shreg_next = {data_s, shreg[DATA_BITS-1:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end

`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (tick_cnt == FULL_LAST) begin
                    tick_next  = '0;
                    par_next   = data_s;
                    state_next = STOP;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                if (tick_cnt == FULL_LAST) begin
                    tick_next  = '0;
                    state_next = DONE;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (state != DONE && state_next == DONE) begin
            armed_next = 1'b0;
        end
    end

    // Outputs load on the edge entering DONE so they are visible during the DONE cycle.
    assign done_enter = (state != DONE) && (state_next == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_complete <= 1'b0;
            char_valid    <= 1'b0;
            rx_char       <= '0;
            framing_error <= 1'b0;
        end else begin
            char_complete <= done_enter;
            char_valid    <= done_enter && !abort_next;
            if (done_enter && !abort_next) begin
                rx_char       <= shreg;
                framing_error <= ~data_s;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_error <= 1'b0;
        end else if (done_enter && !abort_next) begin
            parity_error <= parity_mismatch(shreg, par_bit);
        end
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_char_receiver.sv
// Directed bench for serial_char_receiver; expected characters go through a scoreboard queue.
module tb_serial_char_receiver;
    import serial_rx_pkg::*;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PAR_LEN = OS;
`else
    localparam int PAR_LEN = 0;
`endif
    // enable rise -> START entry (3) + half start bit + data bits + parity + stop bit.
    localparam int FRAME_LAT = 3 + OS / 2 + OS * DB + PAR_LEN + OS;
    localparam int GLITCH_LAT = 3 + OS / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          data;
    logic          char_complete;
    logic          char_valid;
    logic [DB-1:0] rx_char;
    logic          framing_error;
    logic          parity_error;

    typedef struct packed {
        logic [DB-1:0] ch;
        logic          fe;
        logic          pe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   cc_at   = -1;
    int   nvalid  = 0;
    int   npushed = 0;

    serial_char_receiver #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data          (data),
        .char_complete (char_complete),
        .char_valid    (char_valid),
        .rx_char       (rx_char),
        .framing_error (framing_error),
        .parity_error  (parity_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every char_valid pulse must match the oldest pending character.
    always @(negedge clk) begin
        if (char_valid === 1'b1) begin
            nvalid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL spurious_valid: observed char 0x%02h expected no char_valid", rx_char);
            end else begin
                mon_e = sb.pop_front();
                chk("rx_char", 32'(rx_char), 32'(mon_e.ch));
                chk("framing_error", 32'(framing_error), 32'(mon_e.fe));
                chk("parity_error", 32'(parity_error), 32'(mon_e.pe));
                chk("cc_with_valid", 32'(char_complete), 32'd1);
            end
        end
    end

    // Drives the line for n cycles and plays the detector: drop enable on char_complete.
    task automatic hold(input logic b, input int n);
        data = b;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (char_complete === 1'b1) begin
                if (cc_at < 0) cc_at = cyc;
                enable = 1'b0;
            end
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] ch, input logic stop, input logic par);
        exp_t e;
        e.ch = ch;
        e.fe = ~stop;
`ifdef SERIAL_RX_PARITY_EN
        e.pe = par ^ (^ch);
`else
        e.pe = 1'b0;
        if (par) e.pe = 1'b0;
`endif
        sb.push_back(e);
        npushed++;
        cyc    = 0;
        cc_at  = -1;
        enable = 1'b1;
        hold(1'b0, OS);
        for (int i = 0; i < DB; i++) hold(ch[i], OS);
`ifdef SERIAL_RX_PARITY_EN
        hold(par, OS);
`endif
        hold(stop, OS);
        hold(1'b1, OS);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        data   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_char_complete", 32'(char_complete), 32'd0);
        chk("reset_char_valid", 32'(char_valid), 32'd0);
        chk("reset_rx_char", 32'(rx_char), 32'd0);
        chk("reset_framing_error", 32'(framing_error), 32'd0);
        chk("reset_parity_error", 32'(parity_error), 32'd0);
        reset = 1'b0;
        hold(1'b1, 5);

        send_frame(8'h41, 1'b1, 1'b0);
        chk("latency_41", 32'(cc_at), 32'(FRAME_LAT));

        send_frame(8'hA5, 1'b0, 1'b0);
        chk("latency_a5", 32'(cc_at), 32'(FRAME_LAT));
        chk("framing_error_a5", 32'(framing_error), 32'd1);

        // False start: line returns high before the mid-start-bit sample.
        cyc    = 0;
        cc_at  = -1;
        enable = 1'b1;
        hold(1'b0, 4);
        hold(1'b1, 30);
        chk("glitch_cc_latency", 32'(cc_at), 32'(GLITCH_LAT));
        chk("glitch_rx_char_held", 32'(rx_char), 32'hA5);
        chk("glitch_fe_held", 32'(framing_error), 32'd1);
        chk("glitch_no_valid", 32'(nvalid), 32'(npushed));

        // Reset in the middle of 0x3C's data bits.
        cyc    = 0;
        cc_at  = -1;
        enable = 1'b1;
        hold(1'b0, OS);
        hold(1'b0, OS);
        hold(1'b0, OS);
        hold(1'b1, 10);
        reset = 1'b1;
        #1;
        chk("midreset_char_complete", 32'(char_complete), 32'd0);
        chk("midreset_char_valid", 32'(char_valid), 32'd0);
        chk("midreset_rx_char", 32'(rx_char), 32'd0);
        chk("midreset_framing_error", 32'(framing_error), 32'd0);
        chk("midreset_state", 32'(dut.state), 32'(IDLE));
        enable = 1'b0;
        hold(1'b1, 2);
        reset = 1'b0;
        hold(1'b1, 20);
        chk("midreset_no_cc", 32'(cc_at), 32'hFFFF_FFFF);

        send_frame(8'h55, 1'b1, 1'b0);
        chk("latency_55", 32'(cc_at), 32'(FRAME_LAT));

        // Back-to-back with one idle bit between frames.
        send_frame(8'hFF, 1'b1, 1'b0);
        chk("latency_ff", 32'(cc_at), 32'(FRAME_LAT));
        send_frame(8'h00, 1'b1, 1'b0);
        chk("latency_00", 32'(cc_at), 32'(FRAME_LAT));

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        chk("parity_err_set", 32'(parity_error), 32'd1);
        send_frame(8'h07, 1'b1, 1'b1);
        chk("parity_err_clear", 32'(parity_error), 32'd0);
`endif

        hold(1'b1, 300);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("valid_count", 32'(nvalid), 32'(npushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
